bf_out_xbar: RTL and testbench
==============================

# bf_out_xbar

Parametrised output crossbar for the NTT butterfly array. It routes the upper/lower results of `NUM_BF` butterflies onto `2*NUM_BF` memory-bank write lanes under a per-lane source select. The select is issued when the butterfly operands are read and realigned internally through a configurable delay line to match butterfly pipeline latency. It adds valid tracking, optional output registering, and sticky routing/alignment error flags, and sits between the butterfly units and the bank write ports.

## Interface
Parameters:
- `DATA_WIDTH`, 14, coefficient width.
- `NUM_BF`, 2, number of butterflies; lane count `LANES = 2*NUM_BF`.
- `SEL_DELAY`, 13, select-to-data alignment delay in cycles; legal range 1..64.
- `OUT_REG`, 1, 1 = registered outputs, 0 = combinational outputs.
- Derived: `SEL_W = max(1, clog2(LANES))`.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `sel_in_valid`  in  1  the select word on `sel_in` is valid this cycle.
- `sel_in`  in  `LANES*SEL_W`  lane k source index in bits `[k*SEL_W +: SEL_W]`.
- `bf_valid`  in  1  butterfly results are valid this cycle.
- `bf_upper`  in  `NUM_BF*DATA_WIDTH`  butterfly b upper result in slice b.
- `bf_lower`  in  `NUM_BF*DATA_WIDTH`  butterfly b lower result in slice b.
- `err_clr`  in  1  clears the sticky error flags.
- `dout`  out  `LANES*DATA_WIDTH`  lane k output in slice k.
- `dout_valid`  out  1  `dout` carries a routed result this cycle.
- `sel_err`  out  1  sticky: duplicate or out-of-range source index.
- `align_err`  out  1  sticky: `bf_valid` and delayed select valid disagree.

## Operation
- **Source index encoding:** source index s selects butterfly `s>>1`. `s[0]=1` selects the upper result; `s[0]=0` selects the lower result. For NUM_BF=2: 0 → bf0 lower, 1 → bf0 upper, 2 → bf1 lower, 3 → bf1 upper.
- **Delay line:** `SEL_DELAY` stages, each holding `{valid, sel}`. Each cycle every stage shifts by one and stage 0 loads `{sel_in_valid, sel_in}`. The last stage is denoted `{sv_d, sel_d}`.
- **Mux:** lane k takes the source given by `sel_d` lane k. The mux always follows `sel_d`, whether or not `sv_d` is set.
- **Fire:** `fire = bf_valid & sv_d`.
- **OUT_REG=1:** on fire, `dout` registers the mux result and `dout_valid` is 1 the next cycle. Otherwise `dout` holds its value and `dout_valid` is 0.
- **OUT_REG=0:** `dout` is the mux result and `dout_valid = fire`.
- **sel_err:** set when `sv_d=1` and either two lanes of `sel_d` are equal or any index is ≥ LANES. Lanes with an out-of-range index drive 0. Duplicate indices still route, so both lanes carry the same source.
- **align_err:** set when `bf_valid ^ sv_d`. The unmatched data or select is dropped.
- **Error flag priority:** `err_clr` and a new set condition in the same cycle leave the flag set, because set wins. Error flags are never self-clearing.
- **Reset (`rst=0`):** clears all delay-line valid bits and selects, `dout`, `dout_valid`, `sel_err` and `align_err`. A reset mid-stream discards all in-flight selects. No `dout_valid` may appear until a new select has traversed the full delay line.

## Timing
- A select presented at cycle t pairs with `bf_*` presented at cycle t+SEL_DELAY.
- **Latency to output:** `dout_valid` at t+SEL_DELAY+OUT_REG.
- **Throughput:** one select per cycle, with no bubbles required. Back-to-back selects produce back-to-back outputs.
- **Error flags** are registered: visible the cycle after the triggering condition, independent of OUT_REG.
- **Reset values:** `dout=0`, `dout_valid=0`, `sel_err=0`, `align_err=0`.
- After `rst` deasserts at cycle r, the earliest `dout_valid` is r+SEL_DELAY+OUT_REG.
- The block has no backpressure: the consumer must accept every `dout_valid`.

## Test plan
Default parameters (DATA_WIDTH=14, NUM_BF=2, SEL_DELAY=13, OUT_REG=1) unless stated otherwise.
- **Identity routing:** select {0,1,2,3} at cycle 0; at cycle 13 drive bf0 = (upper 0x0101, lower 0x0100) and bf1 = (upper 0x0201, lower 0x0200). Required: at cycle 14, `dout_valid=1` and `dout` lanes 0..3 = 0x0100, 0x0101, 0x0200, 0x0201; `sel_err=0`, `align_err=0`.
- **Streaming permutation:** 20 consecutive selects rotating {3,2,1,0}, {1,0,3,2}, paired with incrementing data. Required: 20 consecutive `dout_valid` cycles with correct permutations and no gaps.
- **Duplicate select:** select {2,2,0,1}. Required: lanes 0 and 1 both equal bf1 lower; `sel_err` rises 14 cycles after the select and stays high until `err_clr`.
- **Misalignment:** `sel_in_valid` at cycle 0 with `bf_valid` held low at cycle 13. Required: no `dout_valid`, `dout` held, `align_err=1` at cycle 14. Then pulse `err_clr` → `align_err=0`.
- **Reset mid-stream:** issue selects at cycles 0..5 and assert `rst=0` at cycle 8 for one cycle. Required: no `dout_valid` from the cancelled selects; all outputs are 0 after reset; a select at cycle 9 yields `dout_valid` at cycle 23.
- **Alternate parameters:** NUM_BF=4, SEL_DELAY=1, OUT_REG=0. Full reverse select {7..0} gives combinational `dout` in the cycle after the select. Any index ≥ 8 is unreachable since SEL_W=3; a duplicate index sets `sel_err`.

Source files
------------

// File: rtl/bf_out_xbar.sv
// Output crossbar for the NTT butterfly array: routes butterfly upper/lower results
// onto bank write lanes using a select word delayed to match butterfly latency.
module bf_out_xbar #(
    parameter  int unsigned DATA_WIDTH = 14,
    parameter  int unsigned NUM_BF     = 2,
    parameter  int unsigned SEL_DELAY  = 13,
    parameter  int unsigned OUT_REG    = 1,
    localparam int unsigned LANES      = 2 * NUM_BF,
    localparam int unsigned SEL_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sel_in_valid,
    input  logic [LANES*SEL_W-1:0]        sel_in,
    input  logic                          bf_valid,
    input  logic [NUM_BF*DATA_WIDTH-1:0]  bf_upper,
    input  logic [NUM_BF*DATA_WIDTH-1:0]  bf_lower,
    input  logic                          err_clr,
    output logic [LANES*DATA_WIDTH-1:0]   dout,
    output logic                          dout_valid,
    output logic                          sel_err,
    output logic                          align_err
);

    logic                   r_dl_valid [SEL_DELAY];
    logic [LANES*SEL_W-1:0] r_dl_sel   [SEL_DELAY];
    logic                   r_sel_err;
    logic                   r_align_err;

    logic                        w_sv_d;
    logic [LANES*SEL_W-1:0]      w_sel_d;
    logic [SEL_W-1:0]            w_idx [LANES];
    logic [LANES*DATA_WIDTH-1:0] w_mux;
    logic                        w_dup;
    logic                        w_oor;
    logic                        w_fire;

    // Select delay line; reset drops every in-flight select
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SEL_DELAY; i++) begin
                r_dl_valid[i] <= 1'b0;
                r_dl_sel[i]   <= '0;
            end
        end else begin
            r_dl_valid[0] <= sel_in_valid;
            r_dl_sel[0]   <= sel_in;
            for (int i = 1; i < SEL_DELAY; i++) begin
                r_dl_valid[i] <= r_dl_valid[i-1];
                r_dl_sel[i]   <= r_dl_sel[i-1];
            end
        end
    end

    assign w_sv_d  = r_dl_valid[SEL_DELAY-1];
    assign w_sel_d = r_dl_sel[SEL_DELAY-1];
    assign w_fire  = bf_valid & w_sv_d;

    // Lane mux plus duplicate / out-of-range detection on the aligned select
    always_comb begin
        w_mux = '0;
        w_dup = 1'b0;
        w_oor = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            w_idx[k] = w_sel_d[k*SEL_W +: SEL_W];
        end
        for (int k = 0; k < LANES; k++) begin
            for (int b = 0; b < NUM_BF; b++) begin
                if (w_idx[k] == SEL_W'(2*b)) begin
                    w_mux[k*DATA_WIDTH +: DATA_WIDTH] = bf_lower[b*DATA_WIDTH +: DATA_WIDTH];
                end
                if (w_idx[k] == SEL_W'(2*b + 1)) begin
                    w_mux[k*DATA_WIDTH +: DATA_WIDTH] = bf_upper[b*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (32'(w_idx[k]) >= LANES) begin
                w_oor = 1'b1;
            end
            for (int j = k + 1; j < LANES; j++) begin
                if (w_idx[k] == w_idx[j]) begin
                    w_dup = 1'b1;
                end
            end
        end
    end

    // Sticky error flags; a new set condition wins over err_clr
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sel_err   <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_sel_err   <= (w_sv_d & (w_dup | w_oor)) | (r_sel_err & ~err_clr);
            r_align_err <= (bf_valid ^ w_sv_d) | (r_align_err & ~err_clr);
        end
    end

    assign sel_err   = r_sel_err;
    assign align_err = r_align_err;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [LANES*DATA_WIDTH-1:0] r_dout;
            logic                        r_dout_valid;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout_valid <= w_fire;
                    if (w_fire) begin
                        r_dout <= w_mux;
                    end
                end
            end

            assign dout       = r_dout;
            assign dout_valid = r_dout_valid;
        end else begin : g_ocomb
            assign dout       = w_mux;
            assign dout_valid = w_fire;
        end
    endgenerate

endmodule

// File: tb/tb_bf_out_xbar.sv
// Scoreboard bench for bf_out_xbar: default build (registered, delay 13) and a
// combinational NUM_BF=4 / SEL_DELAY=1 build, each with its own output monitor.
module tb_bf_out_xbar;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel_in_valid, bf_valid, err_clr;
    logic [7:0]  sel_in;
    logic [27:0] bf_upper, bf_lower;
    logic [55:0] dout;
    logic        dout_valid, sel_err, align_err;

    logic         a_sel_in_valid, a_bf_valid, a_err_clr;
    logic [23:0]  a_sel_in;
    logic [55:0]  a_bf_upper, a_bf_lower;
    logic [111:0] a_dout;
    logic         a_dout_valid, a_sel_err, a_align_err;

    bf_out_xbar dut (
        .clk(clk), .rst(rst), .sel_in_valid(sel_in_valid), .sel_in(sel_in),
        .bf_valid(bf_valid), .bf_upper(bf_upper), .bf_lower(bf_lower),
        .err_clr(err_clr), .dout(dout), .dout_valid(dout_valid),
        .sel_err(sel_err), .align_err(align_err)
    );

    bf_out_xbar #(.DATA_WIDTH(14), .NUM_BF(4), .SEL_DELAY(1), .OUT_REG(0)) dut_a (
        .clk(clk), .rst(rst), .sel_in_valid(a_sel_in_valid), .sel_in(a_sel_in),
        .bf_valid(a_bf_valid), .bf_upper(a_bf_upper), .bf_lower(a_bf_lower),
        .err_clr(a_err_clr), .dout(a_dout), .dout_valid(a_dout_valid),
        .sel_err(a_sel_err), .align_err(a_align_err)
    );

    localparam logic [7:0]  SEL_ID  = {2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [27:0] UP_ID   = {14'h0201, 14'h0101};
    localparam logic [27:0] LO_ID   = {14'h0200, 14'h0100};
    localparam logic [55:0] EXP_ID  = {14'h0201, 14'h0200, 14'h0101, 14'h0100};
    localparam logic [7:0]  SEL_DUP = {2'd1, 2'd0, 2'd2, 2'd2};
    localparam logic [27:0] UP_DUP  = {14'h0B21, 14'h0A11};
    localparam logic [27:0] LO_DUP  = {14'h0B20, 14'h0A10};
    localparam logic [55:0] EXP_DUP = {14'h0A11, 14'h0A10, 14'h0B20, 14'h0B20};
    localparam logic [7:0]  SEL_A   = {2'd0, 2'd1, 2'd2, 2'd3};
    localparam logic [7:0]  SEL_B   = {2'd2, 2'd3, 2'd0, 2'd1};

    localparam logic [23:0]  SEL_REV  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam logic [23:0]  SEL_ADUP = {3'd0, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [55:0]  A_UP     = {14'h1031, 14'h1021, 14'h1011, 14'h1001};
    localparam logic [55:0]  A_LO     = {14'h1030, 14'h1020, 14'h1010, 14'h1000};
    localparam logic [111:0] EXP_REV  = {14'h1000, 14'h1001, 14'h1010, 14'h1011,
                                         14'h1020, 14'h1021, 14'h1030, 14'h1031};
    localparam logic [111:0] EXP_ADUP = {14'h1000, 14'h1030, 14'h1021, 14'h1020,
                                         14'h1011, 14'h1010, 14'h1001, 14'h1000};

    int n_checks = 0;
    int n_fail   = 0;
    int cur_run  = 0;
    int last_run = 0;
    logic [55:0]  exp_q  [$];
    logic [111:0] exp_qa [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Default-build monitor: pop on every dout_valid, track valid run length
    always @(negedge clk) begin
        if (dout_valid) begin
            cur_run++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got dout_valid=1 dout=0x%0h, required dout_valid=0", dout);
            end else begin
                check("dout", 128'(dout), 128'(exp_q.pop_front()));
            end
        end else begin
            if (cur_run != 0) last_run = cur_run;
            cur_run = 0;
        end
    end

    always @(negedge clk) begin
        if (a_dout_valid) begin
            if (exp_qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_valid: got dout_valid=1 dout=0x%0h, required dout_valid=0", a_dout);
            end else begin
                check("a_dout", 128'(a_dout), 128'(exp_qa.pop_front()));
            end
        end
    end

    task automatic drive(input logic sv, input logic [7:0] s, input logic bv,
                         input logic [27:0] up, input logic [27:0] lo, input logic clr);
        @(posedge clk);
        #1;
        sel_in_valid = sv; sel_in = s; bf_valid = bv;
        bf_upper = up; bf_lower = lo; err_clr = clr;
    endtask

    task automatic idle();
        drive(1'b0, 8'h0, 1'b0, 28'h0, 28'h0, 1'b0);
    endtask

    task automatic drive_a(input logic sv, input logic [23:0] s, input logic bv,
                           input logic [55:0] up, input logic [55:0] lo, input logic clr);
        @(posedge clk);
        #1;
        a_sel_in_valid = sv; a_sel_in = s; a_bf_valid = bv;
        a_bf_upper = up; a_bf_lower = lo; a_err_clr = clr;
    endtask

    function automatic logic [13:0] vv(input int j, input int s);
        return 14'(256 + 4*j + s);
    endfunction

    initial begin
        logic [27:0] up, lo;
        int j;

        rst = 1'b0;
        sel_in_valid = 1'b0; sel_in = '0; bf_valid = 1'b0;
        bf_upper = '0; bf_lower = '0; err_clr = 1'b0;
        a_sel_in_valid = 1'b0; a_sel_in = '0; a_bf_valid = 1'b0;
        a_bf_upper = '0; a_bf_lower = '0; a_err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 128'(dout), 128'(0));
        check("rst_dout_valid", 128'(dout_valid), 128'(0));
        check("rst_sel_err", 128'(sel_err), 128'(0));
        check("rst_align_err", 128'(align_err), 128'(0));
        check("rst_a_dout_valid", 128'(a_dout_valid), 128'(0));
        check("rst_a_sel_err", 128'(a_sel_err), 128'(0));
        rst = 1'b1;

        // Identity routing
        drive(1'b1, SEL_ID, 1'b0, 28'h0, 28'h0, 1'b0);
        repeat (12) idle();
        drive(1'b0, 8'h0, 1'b1, UP_ID, LO_ID, 1'b0);
        exp_q.push_back(EXP_ID);
        check("id_valid_early", 128'(dout_valid), 128'(0));
        idle();
        check("id_valid", 128'(dout_valid), 128'(1));
        check("id_sel_err", 128'(sel_err), 128'(0));
        check("id_align_err", 128'(align_err), 128'(0));
        repeat (2) idle();

        // Streaming permutation, 20 back-to-back selects
        for (int i = 0; i < 33; i++) begin
            up = '0;
            lo = '0;
            if (i >= 13) begin
                j = i - 13;
                up = {vv(j, 3), vv(j, 1)};
                lo = {vv(j, 2), vv(j, 0)};
                if (j % 2 == 0) exp_q.push_back({vv(j, 0), vv(j, 1), vv(j, 2), vv(j, 3)});
                else            exp_q.push_back({vv(j, 2), vv(j, 3), vv(j, 0), vv(j, 1)});
            end
            drive(i < 20, (i % 2 == 0) ? SEL_A : SEL_B, i >= 13, up, lo, 1'b0);
        end
        repeat (3) idle();
        check("stream_run_len", 128'(last_run), 128'(20));
        check("stream_align_err", 128'(align_err), 128'(0));

        // Duplicate select
        drive(1'b1, SEL_DUP, 1'b0, 28'h0, 28'h0, 1'b0);
        repeat (12) idle();
        drive(1'b0, 8'h0, 1'b1, UP_DUP, LO_DUP, 1'b0);
        exp_q.push_back(EXP_DUP);
        check("dup_sel_err_before", 128'(sel_err), 128'(0));
        idle();
        check("dup_sel_err_rise", 128'(sel_err), 128'(1));
        repeat (3) idle();
        check("dup_sel_err_sticky", 128'(sel_err), 128'(1));
        drive(1'b0, 8'h0, 1'b0, 28'h0, 28'h0, 1'b1);
        idle();
        check("dup_sel_err_clr", 128'(sel_err), 128'(0));

        // Misalignment: select without data, then data without select
        drive(1'b1, SEL_ID, 1'b0, 28'h0, 28'h0, 1'b0);
        repeat (13) idle();
        idle();
        check("mis_align_err", 128'(align_err), 128'(1));
        check("mis_dout_held", 128'(dout), 128'(EXP_DUP));
        drive(1'b0, 8'h0, 1'b0, 28'h0, 28'h0, 1'b1);
        idle();
        check("mis_align_clr", 128'(align_err), 128'(0));
        drive(1'b0, 8'h0, 1'b1, UP_ID, LO_ID, 1'b0);
        idle();
        check("mis_data_only", 128'(align_err), 128'(1));
        drive(1'b0, 8'h0, 1'b0, 28'h0, 28'h0, 1'b1);
        idle();

        // Reset mid-stream
        for (int c = 0; c < 6; c++) drive(1'b1, SEL_ID, 1'b0, 28'h0, 28'h0, 1'b0);
        drive(1'b0, 8'h0, 1'b1, UP_ID, LO_ID, 1'b0);
        idle();
        idle();
        rst = 1'b0;
        drive(1'b1, SEL_ID, 1'b0, 28'h0, 28'h0, 1'b0);
        check("mid_rst_dout", 128'(dout), 128'(0));
        check("mid_rst_dout_valid", 128'(dout_valid), 128'(0));
        check("mid_rst_align_err", 128'(align_err), 128'(0));
        check("mid_rst_sel_err", 128'(sel_err), 128'(0));
        rst = 1'b1;
        for (int c = 10; c < 23; c++) begin
            if (c == 22) begin
                drive(1'b0, 8'h0, 1'b1, UP_DUP, LO_DUP, 1'b0);
                exp_q.push_back({14'h0B21, 14'h0B20, 14'h0A11, 14'h0A10});
                check("mid_valid_early", 128'(dout_valid), 128'(0));
            end else if (c >= 13 && c <= 18) begin
                drive(1'b0, 8'h0, 1'b1, UP_ID, LO_ID, 1'b0);
            end else begin
                idle();
            end
        end
        idle();
        check("mid_valid_c23", 128'(dout_valid), 128'(1));
        drive(1'b0, 8'h0, 1'b0, 28'h0, 28'h0, 1'b1);
        repeat (2) idle();

        // Alternate build: reverse and duplicate selects, combinational output
        drive_a(1'b1, SEL_REV, 1'b0, 56'h0, 56'h0, 1'b0);
        drive_a(1'b0, 24'h0, 1'b1, A_UP, A_LO, 1'b0);
        exp_qa.push_back(EXP_REV);
        drive_a(1'b0, 24'h0, 1'b0, 56'h0, 56'h0, 1'b0);
        check("a_rev_sel_err", 128'(a_sel_err), 128'(0));
        check("a_rev_align_err", 128'(a_align_err), 128'(0));
        drive_a(1'b1, SEL_ADUP, 1'b0, 56'h0, 56'h0, 1'b0);
        drive_a(1'b0, 24'h0, 1'b1, A_UP, A_LO, 1'b0);
        exp_qa.push_back(EXP_ADUP);
        check("a_dup_sel_err_before", 128'(a_sel_err), 128'(0));
        drive_a(1'b0, 24'h0, 1'b0, 56'h0, 56'h0, 1'b0);
        check("a_dup_sel_err", 128'(a_sel_err), 128'(1));
        repeat (3) drive_a(1'b0, 24'h0, 1'b0, 56'h0, 56'h0, 1'b0);

        check("queue_drained", 128'(exp_q.size()), 128'(0));
        check("a_queue_drained", 128'(exp_qa.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
